axi_read_arbiter: RTL and testbench
===================================

# axi_read_arbiter

Two-master, one-slave arbiter for the `axi_read_if` read channel, sharing the single instruction-memory AXI read slave between the instruction-fetch requester (m0) and the data-side read requester (m1). It grants one complete burst at a time: AR handshake through R last beat. The grant is locked until that burst's final beat completes. It sits between the core's read masters and `imem`, adding one cycle of AR latency and zero cycles on the R path.

## Interface
- `RR_EN`, default 1: 1 = round-robin on simultaneous requests; 0 = fixed priority, m0 always wins.
- `clk`  in  1  system clock, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `m0_if`  `axi_read_if.slave`  bundle  requester 0, fetch side.
- `m1_if`  `axi_read_if.slave`  bundle  requester 1, data side.
- `s_if`  `axi_read_if.master`  bundle  to the shared read slave.
- `grant`  out  1  index of current or last granted master.
- `busy`  out  1  high in ADDR or DATA state.
- Bundle members used: `araddr` [ADDR_WIDTH-1:0], `arlen`, `arvalid`, `arready`, `rdata` [31:0], `rresp`, `rvalid`, `rready`, `rlast`. Widths are as defined in `axi_read_if`; `ADDR_WIDTH` comes from `_riscv_defines`.

## Operation
- States: IDLE, ADDR, DATA.
- IDLE
  - `s_if.arvalid`=0.
  - Both `m*_if.arready`=0.
  - If any `m*_if.arvalid` is high, select a winner:
    - Only one requesting: that one wins.
    - Both requesting, `RR_EN`=1: winner is `!last_grant`.
    - Both requesting, `RR_EN`=0: m0 wins.
  - On the same edge: register `grant`, capture the winner's `araddr` and `arlen` into `addr_q` and `len_q`, go to ADDR.
- ADDR
  - `s_if.arvalid`=1.
  - `s_if.araddr`=`addr_q`, `s_if.arlen`=`len_q`.
  - Winner's `arready` = `s_if.arready`; loser's `arready`=0.
  - On `s_if.arvalid && s_if.arready`, go to DATA.
- DATA
  - `s_if.araddr` and `s_if.arlen` stay driven from `addr_q` and `len_q`, because the slave reads `arlen` during the R phase.
  - `s_if.arvalid`=0.
  - Winner gets `rdata`, `rresp`, `rvalid`, `rlast` from `s_if`.
  - `s_if.rready` = winner's `rready`.
  - Loser sees `rvalid`=0, `rlast`=0, `rdata`=0, `rresp`=OKAY.
  - On `s_if.rvalid && s_if.rready && s_if.rlast`: set `last_grant` ← `grant`, go to IDLE.
- Loser's `arvalid` is held pending, never dropped or acked. It is re-arbitrated in IDLE.
- The arbiter generates no responses itself and never reorders or splits bursts.
- A beat counter `beat_q` increments on each R handshake in DATA and clears in IDLE. It is an internal assertion aid: `rlast` must occur exactly when `beat_q == len_q`.

## Timing
- Reset values:
  - state=IDLE, `grant`=0, `last_grant`=1 (so m0 wins the first tie), `busy`=0.
  - `addr_q`=0, `len_q`=0, `beat_q`=0.
  - All `m*_if.arready`/`rvalid`/`rlast`=0, `s_if.arvalid`=0, `s_if.rready`=0.
- AR latency: master `arvalid` sampled high at edge N → `s_if.arvalid` high in cycle N+1. Master `arready` in cycle N+1 mirrors slave `arready`, which is combinational from the slave.
- R path is purely combinational routing: no added latency, no bubbles between beats.
- The transition DATA→IDLE happens on the edge that completes the last beat. The next grant is decided in IDLE on the following edge, so back-to-back bursts incur minimum 2 idle cycles at `s_if` (IDLE, then ADDR).
- Simultaneous request and last beat: requests seen during DATA are not arbitrated until IDLE. The round-robin pointer is already updated by then.
- Master deasserting `arvalid` while in ADDR is a protocol violation. The captured `addr_q`/`len_q` are still issued.
- Reset mid-burst: async return to IDLE with all outputs at reset values. The slave is reset by the same `rst_n`.

## Test plan
- Single m0 request, araddr=0x40, arlen=0, slave word = addr>>2 → m0 gets rdata=0x10, rlast=1; m1 sees no rvalid; `grant`=0; s_if.arvalid rises 1 cycle after m0.arvalid.
- m1 burst araddr=0x100, arlen=3 → m1 receives 0x40,0x41,0x42,0x43, rlast on the 4th beat only; `busy` high from grant through the last beat.
- Both assert at reset exit, `RR_EN`=1, both persistent → grants alternate m0,m1,m0,m1; each loser's arready stays 0 while the other owns the bus.
- `RR_EN`=0, both requesting continuously → m0 is granted every burst and m1 is never granted. Then drop m0 → m1 is granted in the next IDLE.
- m1 requests during m0's 4-beat DATA → m1 is not acked until m0's rlast handshake; m1's ADDR begins 2 cycles after it.
- `rst_n` pulsed low during beat 2 of a 4-beat burst → state=IDLE, all valid/ready/last outputs 0 immediately. The first post-reset tie goes to m0.

Source files
------------

// File: rtl/axi_read_arbiter_if.sv
// axi_read_if: AXI4 read-address and read-data channel bundle.
// Latency: none, wires only.
// Backpressure: arvalid/arready on AR, rvalid/rready on R.
// Ports: master drives AR and rready; slave drives arready and the R beat.
interface axi_read_if #(
   parameter int ADDR_WIDTH = 32
) ();
   logic [ADDR_WIDTH-1:0] araddr;
   logic [7:0]            arlen;
   logic                  arvalid;
   logic                  arready;
   logic [31:0]           rdata;
   logic [1:0]            rresp;
   logic                  rvalid;
   logic                  rready;
   logic                  rlast;

   modport master (
      output araddr, arlen, arvalid, rready,
      input  arready, rdata, rresp, rvalid, rlast
   );

   modport slave (
      input  araddr, arlen, arvalid, rready,
      output arready, rdata, rresp, rvalid, rlast
   );
endinterface

// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter: two requesters share one AXI read slave, one whole burst (AR through R last) per grant.
// Latency: +1 cycle on AR (request registered into addr_q/len_q), 0 cycles on R (combinational routing).
// Backpressure: loser's arvalid is left pending and unacked; slave arready and winner rready pass straight through.
// Ports: clk, rst_n (async, active low); m0_if fetch requester, m1_if data requester (slave modports);
//        s_if shared slave (master modport); grant = current or last granted index; busy = ADDR or DATA state.
module axi_read_arbiter #(
   parameter bit RR_EN      = 1'b1,
   parameter int ADDR_WIDTH = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   axi_read_if.slave  m0_if,
   axi_read_if.slave  m1_if,
   axi_read_if.master s_if,
   output logic       grant,
   output logic       busy
);

   typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_t;

   state_t                state_q, state_d;
   logic                  grant_q, grant_d;
   logic                  last_grant_q, last_grant_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [7:0]            len_q, len_d;
   logic [7:0]            beat_q, beat_d;

   logic win;
   logic in_addr;
   logic in_data;
   logic sel0;
   logic sel1;
   logic r_hs;

   // On a tie the round-robin pointer favours whoever did not own the last burst.
   always_comb begin
      win = 1'b0;
      if (m0_if.arvalid && m1_if.arvalid) begin
         win = RR_EN ? ~last_grant_q : 1'b0;
      end else begin
         win = m1_if.arvalid;
      end
   end

   assign in_addr = (state_q == ST_ADDR);
   assign in_data = (state_q == ST_DATA);
   assign sel0    = in_data && !grant_q;
   assign sel1    = in_data &&  grant_q;

   // AR side: registered request; araddr/arlen stay valid through DATA for the slave.
   assign s_if.arvalid = in_addr;
   assign s_if.araddr  = addr_q;
   assign s_if.arlen   = len_q;
   assign s_if.rready  = in_data && (grant_q ? m1_if.rready : m0_if.rready);

   assign m0_if.arready = in_addr && !grant_q && s_if.arready;
   assign m1_if.arready = in_addr &&  grant_q && s_if.arready;

   // R side: pure routing; the non-owner sees an idle, OKAY channel.
   assign m0_if.rvalid = sel0 && s_if.rvalid;
   assign m0_if.rlast  = sel0 && s_if.rlast;
   assign m0_if.rdata  = sel0 ? s_if.rdata : 32'h0;
   assign m0_if.rresp  = sel0 ? s_if.rresp : 2'b00;
   assign m1_if.rvalid = sel1 && s_if.rvalid;
   assign m1_if.rlast  = sel1 && s_if.rlast;
   assign m1_if.rdata  = sel1 ? s_if.rdata : 32'h0;
   assign m1_if.rresp  = sel1 ? s_if.rresp : 2'b00;

   assign r_hs = in_data && s_if.rvalid && s_if.rready;

   assign grant = grant_q;
   assign busy  = (state_q != ST_IDLE);

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      addr_d       = addr_q;
      len_d        = len_q;
      beat_d       = beat_q;
      case (state_q)
         ST_IDLE: begin
            beat_d = 8'd0;
            if (m0_if.arvalid || m1_if.arvalid) begin
               grant_d = win;
               addr_d  = win ? m1_if.araddr : m0_if.araddr;
               len_d   = win ? m1_if.arlen  : m0_if.arlen;
               state_d = ST_ADDR;
            end
         end
         ST_ADDR: begin
            if (s_if.arready) begin
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (r_hs) begin
               beat_d = beat_q + 8'd1;
               if (s_if.rlast) begin
                  last_grant_d = grant_q;
                  state_d      = ST_IDLE;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // last_grant resets to 1 so m0 wins the first tie after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         grant_q      <= 1'b0;
         last_grant_q <= 1'b1;
         addr_q       <= '0;
         len_q        <= 8'd0;
         beat_q       <= 8'd0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         addr_q       <= addr_d;
         len_q        <= len_d;
         beat_q       <= beat_d;
      end
   end

   // The slave must end the burst exactly on beat len_q.
   a_rlast_on_final_beat: assert property (@(posedge clk) disable iff (!rst_n)
      r_hs |-> (s_if.rlast == (beat_q == len_q)));

endmodule

// File: tb/tb_axi_read_arbiter.sv
module tb_axi_read_arbiter;

   localparam int NCYC = 1500;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_vec = 0;
   int   n_bad = 0;
   bit   found = 1'b0;

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Arbitration rule: lone requester wins; on a tie RR picks the one not served last, fixed priority picks m0.
   function automatic int pick_winner(input bit r0, input bit r1, input bit rr, input int last);
      if (r0 && r1) return rr ? (1 - last) : 0;
      return r1 ? 1 : 0;
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_inst
      localparam bit RR = (g == 0);

      axi_read_if #(.ADDR_WIDTH(32)) m0_i ();
      axi_read_if #(.ADDR_WIDTH(32)) m1_i ();
      axi_read_if #(.ADDR_WIDTH(32)) s_i ();
      logic grant;
      logic busy;

      axi_read_arbiter #(.RR_EN(RR), .ADDR_WIDTH(32)) dut (
         .clk   (clk),
         .rst_n (rst_n),
         .m0_if (m0_i),
         .m1_if (m1_i),
         .s_if  (s_i),
         .grant (grant),
         .busy  (busy)
      );

      // Reference: who owns the bus and whether its AR has been accepted.
      int          cur;
      int          last_g;
      int          exp_grant;
      bit          ar_done;
      // Requesters: one outstanding burst each.
      bit          mpend [2];
      bit          mdata [2];
      logic [31:0] maddr [2];
      int          mlen  [2];
      int          mbeat [2];
      // Slave: word at address a is a>>2.
      bit          sbusy;
      logic [31:0] sbase;
      int          sbeat;
      // Handshakes expected at the coming rising edge.
      bit          ev_grant, ev_ar, ev_r, ev_last;
      int          ev_win;
      logic [31:0] cap_addr;
      bit          force_req;
      bit          done_f = 1'b0;
      int          n_grant = 0;
      int          n_tie = 0;
      // Values driven into the DUT.
      bit          d_arvalid [2];
      bit          d_rready  [2];
      logic [31:0] d_araddr  [2];
      logic [7:0]  d_arlen   [2];
      bit          s_arready_d, s_rvalid_d, s_rlast_d;
      logic [31:0] s_rdata_d;
      logic [1:0]  s_rresp_d;
      bit          exp_arv, exp_dat, own;
      logic [31:0] o_rdata [2];
      logic [1:0]  o_rresp [2];
      bit          o_arready [2], o_rvalid [2], o_rlast [2];
      string       px;

      initial begin
         px = $sformatf("i%0d", g);
         cur = -1; last_g = 1; exp_grant = 0; ar_done = 1'b0; sbusy = 1'b0;
         for (int i = 0; i < 2; i++) begin
            mpend[i] = 1'b0; mdata[i] = 1'b0; maddr[i] = 32'h0; mlen[i] = 0; mbeat[i] = 0;
            d_arvalid[i] = 1'b0; d_rready[i] = 1'b0; d_araddr[i] = 32'h0; d_arlen[i] = 8'h0;
         end
         s_arready_d = 1'b0; s_rvalid_d = 1'b0; s_rlast_d = 1'b0; s_rdata_d = 32'h0; s_rresp_d = 2'b00;
         ev_grant = 1'b0; ev_ar = 1'b0; ev_r = 1'b0; ev_last = 1'b0; ev_win = 0; cap_addr = 32'h0;
         force_req = 1'b1; sbase = 32'h0; sbeat = 0;
         for (int cyc = 0; cyc < NCYC; cyc++) begin
            // Drive phase (also applies the handshakes of the previous rising edge).
            if (cyc != 0) @(negedge clk);
            if (!rst_n) begin
               cur = -1; last_g = 1; exp_grant = 0; ar_done = 1'b0; sbusy = 1'b0; sbeat = 0;
               ev_grant = 1'b0; ev_ar = 1'b0; ev_r = 1'b0; force_req = 1'b1;
               for (int i = 0; i < 2; i++) begin
                  mpend[i] = 1'b0; mdata[i] = 1'b0; d_arvalid[i] = 1'b0; d_rready[i] = 1'b0;
               end
               s_arready_d = 1'b0; s_rvalid_d = 1'b0; s_rlast_d = 1'b0;
            end else begin
               if (ev_grant) begin
                  cur = ev_win; exp_grant = ev_win; ar_done = 1'b0; n_grant++;
               end
               if (ev_ar) begin
                  ar_done = 1'b1; mpend[cur] = 1'b0; mdata[cur] = 1'b1; mbeat[cur] = 0;
                  sbusy = 1'b1; sbase = cap_addr >> 2; sbeat = 0;
               end
               if (ev_r) begin
                  mbeat[cur]++; sbeat++;
                  if (ev_last) begin
                     mdata[cur] = 1'b0; sbusy = 1'b0; last_g = cur; cur = -1; ar_done = 1'b0;
                  end
               end
               for (int i = 0; i < 2; i++) begin
                  if (!mpend[i] && !mdata[i] && (force_req || $urandom_range(0, 2) == 0)) begin
                     mpend[i] = 1'b1;
                     maddr[i] = 32'($urandom_range(0, 4095)) << 2;
                     mlen[i]  = int'($urandom_range(0, 3));
                  end
                  d_arvalid[i] = mpend[i];
                  d_araddr[i]  = maddr[i];
                  d_arlen[i]   = 8'(mlen[i]);
                  d_rready[i]  = ($urandom_range(0, 3) != 0);
               end
               force_req   = 1'b0;
               s_arready_d = !sbusy && ($urandom_range(0, 1) == 1);
               s_rvalid_d  = sbusy && ($urandom_range(0, 3) != 0);
               s_rdata_d   = sbusy ? sbase + 32'(sbeat) : 32'($urandom);
               s_rresp_d   = 2'($urandom_range(0, 3));
               // The slave takes the burst length from arlen during the R phase.
               s_rlast_d   = sbusy && (32'(sbeat) == 32'(s_i.arlen));
            end
            m0_i.arvalid = d_arvalid[0]; m0_i.araddr = d_araddr[0]; m0_i.arlen = d_arlen[0]; m0_i.rready = d_rready[0];
            m1_i.arvalid = d_arvalid[1]; m1_i.araddr = d_araddr[1]; m1_i.arlen = d_arlen[1]; m1_i.rready = d_rready[1];
            s_i.arready = s_arready_d; s_i.rvalid = s_rvalid_d; s_i.rlast = s_rlast_d;
            s_i.rdata = s_rdata_d; s_i.rresp = s_rresp_d;
            #1;
            if (!rst_n) begin
               chk({px, "_reset_outputs"}, 32'({grant, busy, s_i.arvalid, s_i.rready,
                   m0_i.arready, m0_i.rvalid, m0_i.rlast, m1_i.arready, m1_i.rvalid, m1_i.rlast}), 32'h0);
               continue;
            end
            // Check phase.
            o_arready[0] = m0_i.arready; o_rvalid[0] = m0_i.rvalid; o_rlast[0] = m0_i.rlast;
            o_rdata[0] = m0_i.rdata; o_rresp[0] = m0_i.rresp;
            o_arready[1] = m1_i.arready; o_rvalid[1] = m1_i.rvalid; o_rlast[1] = m1_i.rlast;
            o_rdata[1] = m1_i.rdata; o_rresp[1] = m1_i.rresp;
            exp_arv = (cur >= 0) && !ar_done;
            exp_dat = (cur >= 0) && ar_done;
            chk({px, "_busy"}, 32'(busy), 32'(cur >= 0));
            chk({px, "_grant"}, 32'(grant), 32'(exp_grant));
            chk({px, "_s_arvalid"}, 32'(s_i.arvalid), 32'(exp_arv));
            if (cur >= 0) begin
               chk({px, "_s_araddr"}, s_i.araddr, maddr[cur]);
               chk({px, "_s_arlen"}, 32'(s_i.arlen), 32'(mlen[cur]));
            end
            chk({px, "_s_rready"}, 32'(s_i.rready), 32'(exp_dat && d_rready[cur < 0 ? 0 : cur]));
            for (int i = 0; i < 2; i++) begin
               own = exp_dat && (cur == i);
               chk({px, $sformatf("_m%0d_arready", i)}, 32'(o_arready[i]), 32'(exp_arv && cur == i && s_arready_d));
               chk({px, $sformatf("_m%0d_rvalid", i)}, 32'(o_rvalid[i]), 32'(own && s_rvalid_d));
               if (own && s_rvalid_d) begin
                  chk({px, $sformatf("_m%0d_rdata", i)}, o_rdata[i], (maddr[i] >> 2) + 32'(mbeat[i]));
                  chk({px, $sformatf("_m%0d_rlast", i)}, 32'(o_rlast[i]), 32'(mbeat[i] == mlen[i]));
                  chk({px, $sformatf("_m%0d_rresp", i)}, 32'(o_rresp[i]), 32'(s_rresp_d));
               end else if (!own) begin
                  chk({px, $sformatf("_m%0d_idle_r", i)}, {o_rdata[i][29:0], o_rresp[i]}, 32'h0);
                  chk({px, $sformatf("_m%0d_idle_rlast", i)}, 32'(o_rlast[i]), 32'h0);
               end
            end
            // Record what the coming rising edge will do.
            ev_grant = 1'b0; ev_ar = 1'b0; ev_r = 1'b0; ev_last = 1'b0;
            if (cur < 0 && (d_arvalid[0] || d_arvalid[1])) begin
               ev_grant = 1'b1;
               ev_win   = pick_winner(d_arvalid[0], d_arvalid[1], RR, last_g);
               if (d_arvalid[0] && d_arvalid[1]) n_tie++;
            end
            if (exp_arv && s_arready_d) begin
               ev_ar = 1'b1; cap_addr = s_i.araddr;
            end
            if (exp_dat && s_rvalid_d && d_rready[cur]) begin
               ev_r = 1'b1; ev_last = (mbeat[cur] == mlen[cur]);
            end
         end
         chk({px, "_enough_grants"}, 32'(n_grant > 30), 32'h1);
         chk({px, "_ties_seen"}, 32'(n_tie > 3), 32'h1);
         done_f = 1'b1;
      end
   end

   initial begin
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #3 rst_n = 1'b1;
      // Pull reset in the middle of a multi-beat burst on the round-robin instance.
      for (int c = 0; c < 1000 && !found; c++) begin
         @(negedge clk);
         #2;
         if (c >= 200 && g_inst[0].sbusy && g_inst[0].sbeat == 1 && g_inst[0].mlen[g_inst[0].cur] == 3) found = 1'b1;
      end
      chk("reset_window_found", 32'(found), 32'h1);
      #1 rst_n = 1'b0;
      #1;
      chk("i0_async_reset", 32'({g_inst[0].grant, g_inst[0].busy, g_inst[0].s_i.arvalid, g_inst[0].s_i.rready,
          g_inst[0].m0_i.arready, g_inst[0].m0_i.rvalid, g_inst[0].m0_i.rlast,
          g_inst[0].m1_i.arready, g_inst[0].m1_i.rvalid, g_inst[0].m1_i.rlast}), 32'h0);
      chk("i1_async_reset", 32'({g_inst[1].grant, g_inst[1].busy, g_inst[1].s_i.arvalid, g_inst[1].s_i.rready,
          g_inst[1].m0_i.arready, g_inst[1].m0_i.rvalid, g_inst[1].m0_i.rlast,
          g_inst[1].m1_i.arready, g_inst[1].m1_i.rvalid, g_inst[1].m1_i.rlast}), 32'h0);
      @(negedge clk);
      #3 rst_n = 1'b1;
      for (int c = 0; c < 4000 && !(g_inst[0].done_f && g_inst[1].done_f); c++) @(negedge clk);
      chk("run_completed", 32'(g_inst[0].done_f && g_inst[1].done_f), 32'h1);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
